// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB-first, DIV clocks per bit, repeated R times.
module seq_pattern_tx #(
  parameter int   WIDTH    = 4,
  parameter int   DIV      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_pattern,
  input  logic [7:0]       load_repeat,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] nxt;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic [7:0]       rep_cnt;
  logic             bit_end;
  logic             last_bit;

  assign nxt        = shift << 1;
  assign bit_end    = div_cnt == DW'(DIV - 1);
  assign last_bit   = bit_cnt == BW'(WIDTH - 1);
  assign load_ready = state == S_IDLE;

  // seq_out mirrors shift[WIDTH-1], so every shift/reload also preloads seq_out
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      seq_out   <= IDLE_BIT;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            hold      <= load_pattern;
            shift     <= load_pattern;
            seq_out   <= load_pattern[WIDTH-1];
            seq_valid <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            rep_cnt   <= load_repeat == 8'd0 ? 8'd1 : load_repeat;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bit_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!last_bit) begin
              shift   <= nxt;
              seq_out <= nxt[WIDTH-1];
              bit_cnt <= bit_cnt + 1'b1;
            end else if (rep_cnt > 8'd1) begin
              shift   <= hold;
              seq_out <= hold[WIDTH-1];
              bit_cnt <= '0;
              rep_cnt <= rep_cnt - 8'd1;
            end else begin
              state     <= S_DONE;
              seq_out   <= IDLE_BIT;
              seq_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: three configurations (4/1, 4/3, 1/2) share stimulus and are
// compared each cycle against a timing model derived from accept cycle and pattern.
module tb_seq_pattern_tx;
  logic       clk = 0;
  logic       rst = 0;
  logic       load_valid = 0;
  logic [3:0] load_pattern = 0;
  logic [7:0] load_repeat = 0;
  logic       rd[3], so[3], sv[3], bz[3], dn[3];

  int W[3] = '{4, 4, 1};
  int D[3] = '{1, 3, 2};
  int checks = 0, failures = 0, cyc = 0;
  bit         act[3];
  int         t0[3];
  logic [3:0] mp[3];
  int         mr[3];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(4), .DIV(1)) dut_a (.clk(clk), .rst(rst), .load_valid(load_valid),
    .load_ready(rd[0]), .load_pattern(load_pattern), .load_repeat(load_repeat),
    .seq_out(so[0]), .seq_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
  seq_pattern_tx #(.WIDTH(4), .DIV(3)) dut_b (.clk(clk), .rst(rst), .load_valid(load_valid),
    .load_ready(rd[1]), .load_pattern(load_pattern), .load_repeat(load_repeat),
    .seq_out(so[1]), .seq_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
  seq_pattern_tx #(.WIDTH(1), .DIV(2)) dut_c (.clk(clk), .rst(rst), .load_valid(load_valid),
    .load_ready(rd[2]), .load_pattern(load_pattern[0:0]), .load_repeat(load_repeat),
    .seq_out(so[2]), .seq_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

  // expected {seq_out, seq_valid, busy, done, load_ready} for cycle c
  function automatic logic [4:0] exp_vec(int i, int c);
    int k, n, b;
    if (!act[i]) return 5'b00001;
    k = c - t0[i] + 1;
    n = W[i] * D[i] * mr[i];
    if (k >= 1 && k <= n) begin
      b = ((k - 1) / D[i]) % W[i];
      return {mp[i][W[i]-1-b], 4'b1100};
    end
    return k == n + 1 ? 5'b00010 : 5'b00001;
  endfunction

  function automatic logic [4:0] obs(int i);
    return {so[i], sv[i], bz[i], dn[i], rd[i]};
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++) if (exp_vec(i, cyc) !== 5'b00001) return 0;
    return 1;
  endfunction

  task automatic tick();
    logic [4:0] v;
    bit r[3];
    for (int i = 0; i < 3; i++) begin
      v = exp_vec(i, cyc);
      r[i] = v[0];
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst) act[i] = 0;
      else if (load_valid && r[i]) begin
        act[i] = 1;
        t0[i] = cyc;
        mp[i] = load_pattern;
        mr[i] = load_repeat == 0 ? 1 : int'(load_repeat);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== 5'b00001) begin
          failures++;
          $display("FAIL reset inst=%0d got=%b exp=%b", i, obs(i), 5'b00001);
        end
      end
    end
    rst = 1;
    tick();
    checks++;
    if (rd[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", rd[0]);
    end
  endtask

  task automatic test_basic(input logic [7:0] rep, input string nm);
    logic [3:0] ca = 0;
    logic [11:0] cb = 0;
    int da = -1, db = -1, dc = -1, g = 0;
    logic r6 = 0;
    load_pattern = 4'b1101; load_repeat = rep; load_valid = 1;
    tick();
    load_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i, cyc)) begin
          failures++;
          $display("FAIL %s inst=%0d cyc=%0d got=%b exp=%b", nm, i, cyc, obs(i), exp_vec(i, cyc));
        end
      end
      if (k <= 4) ca = {ca[2:0], so[0]};
      if (k <= 12) cb = {cb[10:0], so[1]};
      if (dn[0]) da = k;
      if (dn[1]) db = k;
      if (dn[2]) dc = k;
      if (k == 6) r6 = rd[0];
    end
    checks += 6;
    if (ca !== 4'b1101) begin failures++; $display("FAIL %s_bits got=%b exp=1101", nm, ca); end
    if (cb !== 12'b111111000111) begin failures++; $display("FAIL %s_div3 got=%b exp=111111000111", nm, cb); end
    if (da != 5) begin failures++; $display("FAIL %s_done_a got=%0d exp=5", nm, da); end
    if (db != 13) begin failures++; $display("FAIL %s_done_b got=%0d exp=13", nm, db); end
    if (dc != 3) begin failures++; $display("FAIL %s_done_w1 got=%0d exp=3", nm, dc); end
    if (r6 !== 1'b1) begin failures++; $display("FAIL %s_ready6 got=%b exp=1", nm, r6); end
    while (!all_idle() && g < 100) begin tick(); g++; end
  endtask

  task automatic test_repeat();
    logic [11:0] ca = 0;
    int nv = 0, nd = 0, da = -1, g = 0;
    load_pattern = 4'b1101; load_repeat = 3; load_valid = 1;
    tick();
    load_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i, cyc)) begin
          failures++;
          $display("FAIL repeat inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), exp_vec(i, cyc));
        end
      end
      if (k <= 12) begin ca = {ca[10:0], so[0]}; nv += sv[0]; end
      if (dn[0]) begin nd++; da = k; end
    end
    checks += 3;
    if (ca !== 12'b110111011101) begin failures++; $display("FAIL repeat_bits got=%b exp=110111011101", ca); end
    if (nv != 12) begin failures++; $display("FAIL repeat_valid got=%0d exp=12", nv); end
    if (nd != 1 || da != 13) begin failures++; $display("FAIL repeat_done got=%0d@%0d exp=1@13", nd, da); end
    while (!all_idle() && g < 100) begin tick(); g++; end
  endtask

  task automatic test_busy_load();
    logic [3:0] ca = 0;
    int nr = 0, da = -1, g = 0;
    load_pattern = 4'b1101; load_repeat = 1; load_valid = 1;
    tick();
    load_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i, cyc)) begin
          failures++;
          $display("FAIL busy_load inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), exp_vec(i, cyc));
        end
      end
      if (k <= 4) ca = {ca[2:0], so[0]};
      if (k <= 5) nr += rd[0];
      if (dn[0]) da = k;
      load_valid = k == 2;
      load_pattern = k == 2 ? 4'b0000 : 4'b1101;
      load_repeat = k == 2 ? 8'd5 : 8'd1;
    end
    checks += 3;
    if (ca !== 4'b1101) begin failures++; $display("FAIL busy_load_bits got=%b exp=1101", ca); end
    if (nr != 0) begin failures++; $display("FAIL busy_load_ready got=%0d exp=0", nr); end
    if (da != 5) begin failures++; $display("FAIL busy_load_done got=%0d exp=5", da); end
    while (!all_idle() && g < 100) begin tick(); g++; end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ca = 0;
    int nd = 0, g = 0;
    load_pattern = 4'b1101; load_repeat = 3; load_valid = 1;
    tick();
    load_valid = 0;
    tick();
    rst = 0;
    tick();
    checks++;
    if ({so[0], sv[0], bz[0], dn[0]} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0000", {so[0], sv[0], bz[0], dn[0]});
    end
    rst = 1; load_pattern = 4'b1011; load_repeat = 1; load_valid = 1;
    tick();
    load_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i, cyc)) begin
          failures++;
          $display("FAIL reset_mid inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), exp_vec(i, cyc));
        end
      end
      if (k <= 4) ca = {ca[2:0], so[0]};
      if (k <= 4) nd += dn[0];
    end
    checks += 2;
    if (ca !== 4'b1011) begin failures++; $display("FAIL reset_mid_reload got=%b exp=1011", ca); end
    if (nd != 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", nd); end
    while (!all_idle() && g < 100) begin tick(); g++; end
  endtask

  task automatic test_repeat_max();
    int nv = 0, nd = 0, da = -1, k = 1;
    load_pattern = 4'($urandom); load_repeat = 255; load_valid = 1;
    tick();
    load_valid = 0;
    while (k < 4000) begin
      if (k > 1) tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i, cyc)) begin
          failures++;
          $display("FAIL repeat_max inst=%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), exp_vec(i, cyc));
        end
      end
      nv += sv[0];
      if (dn[0]) begin nd++; da = k; end
      if (all_idle()) break;
      k++;
    end
    checks += 3;
    if (nv != 1020) begin failures++; $display("FAIL repeat_max_valid got=%0d exp=1020", nv); end
    if (nd != 1 || da != 1021) begin failures++; $display("FAIL repeat_max_done got=%0d@%0d exp=1@1021", nd, da); end
    if (!all_idle()) begin failures++; $display("FAIL repeat_max_timeout got=busy exp=idle"); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      int g = 0;
      load_pattern = 4'($urandom); load_repeat = 8'($urandom_range(0, 4)); load_valid = 1;
      tick();
      while ((g < 30 || !all_idle()) && g < 4000) begin
        load_valid = g < 30 && $urandom_range(0, 3) == 0;
        load_pattern = 4'($urandom);
        load_repeat = 8'($urandom_range(0, 3));
        rst = !(g < 30 && $urandom_range(0, 40) == 0);
        if (g > 0) tick();
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs(i) !== exp_vec(i, cyc)) begin
            failures++;
            $display("FAIL random it=%0d inst=%0d cyc=%0d got=%b exp=%b", it, i, cyc, obs(i), exp_vec(i, cyc));
          end
        end
        g++;
      end
      load_valid = 0; rst = 1;
      checks++;
      if (!all_idle()) begin failures++; $display("FAIL random_timeout it=%0d got=busy exp=idle", it); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic(8'd1, "basic");
    test_repeat();
    test_basic(8'd0, "repeat_zero");
    test_busy_load();
    test_reset_mid();
    test_repeat_max();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
